// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: push side, pop side and occupancy status.
// The SYNC_FIFO_ERR_FLAGS_EN macro adds the sticky overflow/underflow flags.
interface sync_fifo_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PTR_SZ = 16
);
  logic              pushValid;
  logic              pushReady;
  logic [WIDTH-1:0]  pushData;
  logic              popValid;
  logic              popReady;
  logic [WIDTH-1:0]  popData;
  logic [PTR_SZ-1:0] count;
  logic              full;
  logic              empty;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic              overflowErr;
  logic              underflowErr;

  modport master (
    output pushValid, pushData, popReady,
    input  pushReady, popValid, popData, count, full, empty, overflowErr, underflowErr
  );

  modport slave (
    input  pushValid, pushData, popReady,
    output pushReady, popValid, popData, count, full, empty, overflowErr, underflowErr
  );
`else
  modport master (
    output pushValid, pushData, popReady,
    input  pushReady, popValid, popData, count, full, empty
  );

  modport slave (
    input  pushValid, pushData, popReady,
    output pushReady, popValid, popData, count, full, empty
  );
`endif
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflowErr/underflowErr outputs.
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned PTR_SZ = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_fifo_if.slave bus
);

  localparam int unsigned       AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_SZ-1:0] DepthCnt = PTR_SZ'(DEPTH);
  localparam logic [PTR_SZ-1:0] LastIdx  = PTR_SZ'(DEPTH - 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_SZ-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_SZ-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_SZ-1:0] count_q, count_d;
  logic              full, empty;
  logic              push_fire, pop_fire;
  logic              unused_ptr;

  // Pointers never exceed DEPTH-1, so only the low AW bits address memory.
  assign unused_ptr = ^{wr_ptr_q, rd_ptr_q};

  always_comb begin
    full      = (count_q == DepthCnt);
    empty     = (count_q == '0);
    push_fire = bus.pushValid && !full;
    pop_fire  = bus.popReady && !empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_fire) begin
      wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PTR_SZ'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PTR_SZ'(1);
    end

    if (push_fire && !pop_fire) begin
      count_d = count_q + PTR_SZ'(1);
    end else if (pop_fire && !push_fire) begin
      count_d = count_q - PTR_SZ'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; popData is gated by empty instead.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.pushData;
    end
  end

  always_comb begin
    bus.pushReady = !full;
    bus.popValid  = !empty;
    bus.popData   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    bus.count     = count_q;
    bus.full      = full;
    bus.empty     = empty;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.pushValid && full) begin
        overflow_q <= 1'b1;
      end
      if (bus.popReady && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflowErr  = overflow_q;
  assign bus.underflowErr = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus queues expected words, a negedge
// monitor pops and compares them; status is checked against an occupancy model.
module tb_sync_fifo;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 12;
  localparam int unsigned PTR_SZ = 16;

  logic clk;
  logic rst_n;

  sync_fifo_if #(.WIDTH(WIDTH), .PTR_SZ(PTR_SZ)) bus ();

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_SZ(PTR_SZ)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned      total_cnt = 0;
  int unsigned      pass_cnt  = 0;
  logic [WIDTH-1:0] exp_q [$];
  int               m_count   = 0;
  int unsigned      m_pops    = 0;
  int unsigned      seen_pops = 0;
  logic             m_ovf     = 1'b0;
  logic             m_udf     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic check_status();
    chk("count", 32'(bus.count), 32'(m_count));
    chk("full", 32'(bus.full), 32'(m_count == DEPTH));
    chk("empty", 32'(bus.empty), 32'(m_count == 0));
    chk("pushReady", 32'(bus.pushReady), 32'(m_count != DEPTH));
    chk("popValid", 32'(bus.popValid), 32'(m_count != 0));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflowErr", 32'(bus.overflowErr), 32'(m_ovf));
    chk("underflowErr", 32'(bus.underflowErr), 32'(m_udf));
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input logic pv, input logic [WIDTH-1:0] pd, input logic pr);
    logic push_ok, pop_ok;
    bus.pushValid = pv;
    bus.pushData  = pd;
    bus.popReady  = pr;
    push_ok = pv && (m_count < DEPTH);
    pop_ok  = pr && (m_count > 0);
    if (pv && m_count == DEPTH) m_ovf = 1'b1;
    if (pr && m_count == 0) m_udf = 1'b1;
    if (push_ok) exp_q.push_back(pd);
    if (pop_ok) m_pops++;
    m_count = m_count + int'(push_ok) - int'(pop_ok);
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, '0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.popValid && bus.popReady) begin
      seen_pops++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL pop_unexpected @%0t: got %0h, expected no transfer", $time, bus.popData);
      end else begin
        chk("pop_data", 32'(bus.popData), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.pushValid = 1'b0;
    bus.pushData  = '0;
    bus.popReady  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_pushReady", 32'(bus.pushReady), 32'd1);
    chk("rst_popValid", 32'(bus.popValid), 32'd0);
    chk("rst_popData", 32'(bus.popData), 32'd0);
    @(posedge clk);
    #1;

    // Ordering: three words in, then drained.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("order_count3", 32'(bus.count), 32'd3);
    repeat (3) pop();
    chk("order_empty", 32'(bus.empty), 32'd1);

    // Pop while empty has no state effect.
    pop();

    // Fill to full, reject 0xFF, drain.
    for (int i = 0; i < 12; i++) push(8'(i));
    chk("fill_count12", 32'(bus.count), 32'd12);
    chk("fill_full", 32'(bus.full), 32'd1);
    push(8'hFF);
    chk("reject_count12", 32'(bus.count), 32'd12);
    repeat (12) pop();

    // Wrap: push 8, pop 8, push 10 crosses index 11 -> 0.
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    repeat (8) pop();
    for (int i = 0; i < 10; i++) push(8'h90 + 8'(i));
    repeat (5) pop();
    chk("steady_count5", 32'(bus.count), 32'd5);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h40 + 8'(i), 1'b1);
    chk("steady_hold5", 32'(bus.count), 32'd5);
    repeat (5) pop();

    // Full boundary: push+pop takes only the pop.
    for (int i = 0; i < 12; i++) push(8'hC0 + 8'(i));
    step(1'b1, 8'hEE, 1'b1);
    chk("full_pushpop", 32'(bus.count), 32'd11);
    repeat (11) pop();

    // Empty boundary: push+pop takes only the push.
    step(1'b1, 8'h5A, 1'b1);
    chk("empty_pushpop", 32'(bus.count), 32'd1);
    pop();

    // Asynchronous reset mid-cycle at count 7.
    for (int i = 0; i < 7; i++) push(8'h60 + 8'(i));
    bus.pushValid = 1'b0;
    bus.popReady  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_empty", 32'(bus.empty), 32'd1);
    chk("async_popValid", 32'(bus.popValid), 32'd0);
    chk("async_popData", 32'(bus.popData), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("async_ovf_clr", 32'(bus.overflowErr), 32'd0);
    chk("async_udf_clr", 32'(bus.underflowErr), 32'd0);
`endif
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First post-reset pop returns the first post-reset push.
    push(8'hA5);
    push(8'hB6);
    pop();
    pop();
    step(1'b0, '0, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("pop_total", seen_pops, m_pops);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout @%0t: bench did not complete", $time);
    $fatal(1, "timeout");
  end

endmodule
